instr_fetch_queue: RTL and testbench

- Parametrised successor to the single-entry instruction register in the multicycle MIPS datapath.
- Buffers up to DEPTH fetched instructions, each with its fetch PC, in a FIFO with valid/ready handshakes.
- Decodes the head entry into op/rs/rt/rd/shamt/funct/imm/jta fields.
- Sits between instruction memory and the control FSM. Supports a flush on branch/jump redirect.

---
 rtl/instr_fetch_queue.sv | 138 +++++++++++++
 tb/tb_instr_fetch_queue.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// ----------------------------------------------------------------------------
// instr_fetch_queue
//   FIFO of fetched instructions (with their fetch PCs) sitting between
//   instruction memory and the control FSM. It replaces the single-entry
//   instruction register of the multicycle MIPS datapath. The head entry is
//   decoded into the standard MIPS instruction fields.
//
// Parameters
//   DEPTH : number of entries, power of two in 2..16
//   IW    : instruction width (field decode assumes 32)
//   PCW   : width of the PC stored with each instruction
//
// Ports
//   clk        in   system clock, rising-edge
//   reset      in   asynchronous active-high reset (clears pointers/count)
//   flush      in   synchronous discard of all entries (branch/jump redirect)
//   in_valid   in   memory presents an instruction
//   in_ready   out  queue can accept an instruction (count != DEPTH)
//   in_instr   in   fetched instruction word
//   in_pc      in   PC of in_instr
//   out_valid  out  head entry valid (count != 0)
//   out_pop    in   control consumes the head entry
//   out_instr  out  head instruction word (0 when empty)
//   out_pc     out  head PC (0 when empty)
//   op..jta    out  decoded fields of the head word (0 when empty)
//   count      out  current occupancy 0..DEPTH
// ----------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter  int DEPTH = 4,
  parameter  int IW    = 32,
  parameter  int PCW   = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IW-1:0]  in_instr,
  input  logic [PCW-1:0] in_pc,
  output logic           out_valid,
  input  logic           out_pop,
  output logic [IW-1:0]  out_instr,
  output logic [PCW-1:0] out_pc,
  output logic [5:0]     op,
  output logic [4:0]     rs,
  output logic [4:0]     rt,
  output logic [4:0]     rd,
  output logic [4:0]     shamt,
  output logic [5:0]     funct,
  output logic [15:0]    imm,
  output logic [25:0]    jta,
  output logic [CW-1:0]  count
);

  // Storage is deliberately not reset; validity is tracked by count_q alone.
  logic [IW-1:0]  instr_mem_q [DEPTH];
  logic [PCW-1:0] pc_mem_q    [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic push_s;
  logic pop_s;

  // Handshake flags depend only on registered count, never on in_valid/out_pop.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != {CW{1'b0}});
  assign count     = count_q;

  assign push_s = in_valid && in_ready;
  assign pop_s  = out_pop && out_valid;

  // Next-state for pointers and occupancy; flush overrides any push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = {AW{1'b0}};
      wr_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= {AW{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write; a push in a flush cycle is discarded.
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      instr_mem_q[wr_ptr_q] <= in_instr;
      pc_mem_q[wr_ptr_q]    <= in_pc;
    end
  end

  // Head is presented with zero latency; an empty queue shows an all-zero NOP.
  assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : {IW{1'b0}};
  assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : {PCW{1'b0}};

  assign op    = out_instr[31:26];
  assign rs    = out_instr[25:21];
  assign rt    = out_instr[20:16];
  assign rd    = out_instr[15:11];
  assign shamt = out_instr[10:6];
  assign funct = out_instr[5:0];
  assign imm   = out_instr[15:0];
  assign jta   = out_instr[25:0];

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_instr;
  logic [31:0]   in_pc;
  logic          out_valid;
  logic          out_pop;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic [5:0]    op;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [4:0]    shamt;
  logic [5:0]    funct;
  logic [15:0]   imm;
  logic [25:0]   jta;
  logic [CW-1:0] count;

  instr_fetch_queue #(.DEPTH(DEPTH), .IW(32), .PCW(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_pop(out_pop), .out_instr(out_instr), .out_pc(out_pc),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .jta(jta), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a plain queue of {instr, pc} entries.
  logic [63:0] mq[$];

  typedef struct {
    logic        fl;
    logic        iv;
    logic        pop;
    logic [31:0] instr;
    logic [31:0] pc;
    int          e_count;
    logic        e_valid;
    logic        e_ready;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_fields(input string tag, input logic [31:0] w);
    chk({tag, " op"},    64'(op),    64'(w[31:26]));
    chk({tag, " rs"},    64'(rs),    64'(w[25:21]));
    chk({tag, " rt"},    64'(rt),    64'(w[20:16]));
    chk({tag, " rd"},    64'(rd),    64'(w[15:11]));
    chk({tag, " shamt"}, 64'(shamt), 64'(w[10:6]));
    chk({tag, " funct"}, 64'(funct), 64'(w[5:0]));
    chk({tag, " imm"},   64'(imm),   64'(w[15:0]));
    chk({tag, " jta"},   64'(jta),   64'(w[25:0]));
  endtask

  // One clock cycle with model update and full output comparison.
  task automatic cycle(input logic fl, input logic iv, input logic pop,
                       input logic [31:0] instr, input logic [31:0] pc);
    bit do_push;
    bit do_pop;
    logic [31:0] ew;
    logic [31:0] ep;
    flush = fl; in_valid = iv; out_pop = pop; in_instr = instr; in_pc = pc;
    do_push = iv && (mq.size() < DEPTH);
    do_pop  = pop && (mq.size() > 0);
    if (fl) begin
      mq.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({instr, pc});
    end
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0; out_pop = 1'b0;
    ew = (mq.size() > 0) ? mq[0][63:32] : 32'h0;
    ep = (mq.size() > 0) ? mq[0][31:0]  : 32'h0;
    chk("mdl count", 64'(count), 64'(mq.size()));
    chk("mdl out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("mdl in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
    chk("mdl out_instr", 64'(out_instr), 64'(ew));
    chk("mdl out_pc", 64'(out_pc), 64'(ep));
    chk_fields("mdl", ew);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_pop = 1'b0;
    in_instr = 32'h0; in_pc = 32'h0;

    // {flush, in_valid, out_pop, instr, pc, exp count, exp valid, exp ready, exp instr, exp pc}
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h8C480004, 32'h00400000, 1, 1'b1, 1'b1, 32'h8C480004, 32'h00400000};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h11111111, 32'h00400004, 2, 1'b1, 1'b1, 32'h8C480004, 32'h00400000};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h22222222, 32'h00400008, 3, 1'b1, 1'b1, 32'h8C480004, 32'h00400000};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h33333333, 32'h0040000C, 4, 1'b1, 1'b0, 32'h8C480004, 32'h00400000};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h00400010, 4, 1'b1, 1'b0, 32'h8C480004, 32'h00400000};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        3, 1'b1, 1'b1, 32'h11111111, 32'h00400004};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        2, 1'b1, 1'b1, 32'h22222222, 32'h00400008};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h44444444, 32'h00400010, 2, 1'b1, 1'b1, 32'h33333333, 32'h0040000C};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 32'h55555555, 32'h00400014, 0, 1'b0, 1'b1, 32'h0,        32'h0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h08100000, 32'h00400018, 1, 1'b1, 1'b1, 32'h08100000, 32'h00400018};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        0, 1'b0, 1'b1, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        0, 1'b0, 1'b1, 32'h0,        32'h0};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset count", 64'(count), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_instr", 64'(out_instr), 64'd0);

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      flush = vecs[i].fl; in_valid = vecs[i].iv; out_pop = vecs[i].pop;
      in_instr = vecs[i].instr; in_pc = vecs[i].pc;
      @(posedge clk);
      #1;
      flush = 1'b0; in_valid = 1'b0; out_pop = 1'b0;
      chk($sformatf("vec%0d count", i), 64'(count), 64'(vecs[i].e_count));
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(vecs[i].e_ready));
      chk($sformatf("vec%0d out_instr", i), 64'(out_instr), 64'(vecs[i].e_instr));
      chk($sformatf("vec%0d out_pc", i), 64'(out_pc), 64'(vecs[i].e_pc));
      if (i == 0) begin
        chk("push op", 64'(op), 64'h23);
        chk("push rs", 64'(rs), 64'd2);
        chk("push rt", 64'(rt), 64'd8);
        chk("push imm", 64'(imm), 64'h0004);
      end
      if (i == 9) begin
        chk("empty push op", 64'(op), 64'h02);
        chk("empty push jta", 64'(jta), 64'h0100000);
      end
    end
    // Queue is empty here; keep the model in step.
    mq.delete();

    // Flushed word must not reappear after the next push.
    cycle(1'b0, 1'b1, 1'b0, 32'hA0A0A0A0, 32'h00000100);
    cycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

    // Simultaneous push/pop at count=2, 10 cycles to wrap the pointers.
    cycle(1'b0, 1'b1, 1'b0, 32'hB0000000, 32'h00000200);
    cycle(1'b0, 1'b1, 1'b0, 32'hB0000001, 32'h00000204);
    for (int k = 2; k < 12; k++) begin
      cycle(1'b0, 1'b1, 1'b1, 32'hB0000000 + 32'(k), 32'h00000200 + 32'(4 * k));
    end

    // Asynchronous reset with two entries held, checked before any edge.
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async reset count", 64'(count), 64'd0);
    chk("async reset out_valid", 64'(out_valid), 64'd0);
    chk("async reset in_ready", 64'(in_ready), 64'd1);
    chk("async reset op", 64'(op), 64'd0);
    chk("async reset jta", 64'(jta), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    cycle(1'b0, 1'b1, 1'b0, 32'h8C480004, 32'h00400000);

    // Randomised traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 1) == 1), $urandom(), $urandom());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
